// File: rtl/hazard_ctrl.sv
// ----------------------------------------------------------------------------
// hazard_ctrl
//   Pipeline hazard controller for the 16-bit core. Produces every front-end
//   stall and squash, plus the bubble select into the ID/EX register.
//
//   Hazards handled:
//     - load-use between EX (load) and ID (consumer)
//     - taken branch/jump redirect from EX, squashed for FLUSH_CYCLES cycles
//     - back-to-back stack push/pop, spaced by STACK_LAT bubbles
//
//   Ports:
//     clk, reset            clock (rising edge), async active-low reset
//     rs1_ID, rs2_ID        source registers of the ID instruction
//     Read_Enable_1/2_ID    the matching source register is really read
//     Stack_In/Out_Enable_ID  ID holds a push / pop
//     rd_EX, Write_Enable_EX, Mem_RD_EX  EX destination, writes, is a load
//     Redirect_EX           taken branch/jump resolved in EX this cycle
//     Stall_PC, Stall_IF_ID hold PC / IF-ID register (combinational)
//     Flush_IF_ID           clear IF/ID to NOP (combinational)
//     MUX_ID_PM             inject a NOP into ID/EX (combinational)
//     Hz_State              registered state: 0 IDLE, 1 FLUSH, 2 STACK_WAIT
//     Bubble_Count          registered saturating count of MUX_ID_PM cycles
//
//   Flow semantics: the ID instruction advances to EX in a cycle where none
//   of flush/stall is active ("issue"); Stall_* low acts as the ready of
//   the ID stage, and the ID instruction is the valid item that holds its
//   contents until accepted. A squash discards the ID instruction.
// ----------------------------------------------------------------------------
module hazard_ctrl #(
    parameter int REG_AW       = 4,
    parameter int FLUSH_CYCLES = 2,
    parameter int STACK_LAT    = 2,
    parameter int CNT_W        = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] rs1_ID,
    input  logic [REG_AW-1:0] rs2_ID,
    input  logic              Read_Enable_1_ID,
    input  logic              Read_Enable_2_ID,
    input  logic              Stack_In_Enable_ID,
    input  logic              Stack_Out_Enable_ID,
    input  logic [REG_AW-1:0] rd_EX,
    input  logic              Write_Enable_EX,
    input  logic              Mem_RD_EX,
    input  logic              Redirect_EX,
    output logic              Stall_PC,
    output logic              Stall_IF_ID,
    output logic              Flush_IF_ID,
    output logic              MUX_ID_PM,
    output logic [1:0]        Hz_State,
    output logic [15:0]       Bubble_Count
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        FLUSH      = 2'd1,
        STACK_WAIT = 2'd2
    } hz_state_t;

    // Remaining squash cycles after the redirect cycle itself.
    localparam logic [CNT_W-1:0] FL_RELOAD  = CNT_W'(FLUSH_CYCLES - 1);
    localparam logic [CNT_W-1:0] STK_RELOAD = CNT_W'(STACK_LAT);

    hz_state_t        state;
    logic [CNT_W-1:0] fl_cnt;
    logic [CNT_W-1:0] stk_cnt;
    logic [15:0]      bubble_cnt;

    logic lu;
    logic stk_op;
    logic sh;
    logic flush_act;
    logic stall_act;
    logic bubble;
    logic issue;

    always_comb begin
        lu = Mem_RD_EX & Write_Enable_EX & (rd_EX != '0) &
             ((Read_Enable_1_ID & (rs1_ID == rd_EX)) |
              (Read_Enable_2_ID & (rs2_ID == rd_EX)));
        stk_op    = Stack_In_Enable_ID | Stack_Out_Enable_ID;
        sh        = stk_op & (stk_cnt != '0);
        // Squash dominates: a redirect makes any stall in ID moot.
        flush_act = Redirect_EX | ((state == FLUSH) & (fl_cnt != '0));
        stall_act = ~flush_act & (lu | sh);
        bubble    = flush_act | stall_act;
        issue     = stk_op & ~bubble;
    end

    // Combinational outputs are gated by reset so they read 0 during reset
    // even while inputs such as Redirect_EX are active.
    assign Flush_IF_ID  = reset & flush_act;
    assign Stall_PC     = reset & stall_act;
    assign Stall_IF_ID  = reset & stall_act;
    assign MUX_ID_PM    = reset & bubble;
    assign Hz_State     = state;
    assign Bubble_Count = bubble_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            fl_cnt     <= '0;
            stk_cnt    <= '0;
            bubble_cnt <= '0;
        end else begin
            // State and flush counter
            if (Redirect_EX) begin
                fl_cnt <= FL_RELOAD;
                state  <= (FL_RELOAD != '0) ? FLUSH : IDLE;
            end else if (flush_act) begin
                // Here state is FLUSH with a nonzero count.
                fl_cnt <= fl_cnt - CNT_W'(1);
                state  <= (fl_cnt != CNT_W'(1)) ? FLUSH : IDLE;
            end else begin
                state  <= sh ? STACK_WAIT : IDLE;
            end

            // Stack spacing counter keeps running through flushes: the stack
            // op already in flight is real. A squashed op never reloads it.
            if (issue) begin
                stk_cnt <= STK_RELOAD;
            end else if (stk_cnt != '0) begin
                stk_cnt <= stk_cnt - CNT_W'(1);
            end

            if (bubble && (bubble_cnt != 16'hFFFF)) begin
                bubble_cnt <= bubble_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// ----------------------------------------------------------------------------
// tb_hazard_ctrl
//   Directed scenario tasks plus a randomized run checked against a
//   cycle-history reference model (last redirect cycle, last stack issue
//   cycle, running bubble total).
// ----------------------------------------------------------------------------
module tb_hazard_ctrl;

    localparam int REG_AW = 4;
    localparam int FC     = 2;
    localparam int SL     = 2;
    localparam int CNT_W  = 3;

    // ------------------------------------------------------------ clock/reset
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [REG_AW-1:0] rs1_ID, rs2_ID, rd_EX;
    logic Read_Enable_1_ID, Read_Enable_2_ID;
    logic Stack_In_Enable_ID, Stack_Out_Enable_ID;
    logic Write_Enable_EX, Mem_RD_EX, Redirect_EX;
    logic Stall_PC, Stall_IF_ID, Flush_IF_ID, MUX_ID_PM;
    logic [1:0]  Hz_State;
    logic [15:0] Bubble_Count;

    // {Stall_PC, Stall_IF_ID, Flush_IF_ID, MUX_ID_PM}
    logic [3:0] outs;
    assign outs = {Stall_PC, Stall_IF_ID, Flush_IF_ID, MUX_ID_PM};
    localparam logic [3:0] O_NONE  = 4'b0000;
    localparam logic [3:0] O_STALL = 4'b1101;
    localparam logic [3:0] O_FLUSH = 4'b0011;

    int checks = 0;
    int errors = 0;

    hazard_ctrl #(
        .REG_AW(REG_AW), .FLUSH_CYCLES(FC), .STACK_LAT(SL), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset),
        .rs1_ID(rs1_ID), .rs2_ID(rs2_ID),
        .Read_Enable_1_ID(Read_Enable_1_ID), .Read_Enable_2_ID(Read_Enable_2_ID),
        .Stack_In_Enable_ID(Stack_In_Enable_ID), .Stack_Out_Enable_ID(Stack_Out_Enable_ID),
        .rd_EX(rd_EX), .Write_Enable_EX(Write_Enable_EX), .Mem_RD_EX(Mem_RD_EX),
        .Redirect_EX(Redirect_EX),
        .Stall_PC(Stall_PC), .Stall_IF_ID(Stall_IF_ID), .Flush_IF_ID(Flush_IF_ID),
        .MUX_ID_PM(MUX_ID_PM), .Hz_State(Hz_State), .Bubble_Count(Bubble_Count)
    );

    // ---------------------------------------------------------------- drivers
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic idle_in();
        rs1_ID = '0; rs2_ID = '0; rd_EX = '0;
        Read_Enable_1_ID = 1'b0; Read_Enable_2_ID = 1'b0;
        Stack_In_Enable_ID = 1'b0; Stack_Out_Enable_ID = 1'b0;
        Write_Enable_EX = 1'b0; Mem_RD_EX = 1'b0; Redirect_EX = 1'b0;
    endtask

    task automatic set_load_ex(input logic [REG_AW-1:0] rd);
        Mem_RD_EX = 1'b1; Write_Enable_EX = 1'b1; rd_EX = rd;
    endtask

    // ------------------------------------------------------- reference model
    int         m_cyc, m_last_redir, m_last_issue, m_bubbles;
    bit         m_prev_flush, m_prev_sh, m_lu, m_squash, m_stk_haz, m_stk;
    logic [3:0] exp_outs;
    logic [1:0] exp_state;

    task automatic model_init();
        m_cyc = 0; m_last_redir = -100; m_last_issue = -100; m_bubbles = 0;
        m_prev_flush = 1'b0; m_prev_sh = 1'b0;
    endtask

    task automatic model_eval();
        int d;
        m_lu = Mem_RD_EX && Write_Enable_EX && (rd_EX != 0) &&
               ((Read_Enable_1_ID && rs1_ID == rd_EX) || (Read_Enable_2_ID && rs2_ID == rd_EX));
        m_stk     = Stack_In_Enable_ID || Stack_Out_Enable_ID;
        d         = m_cyc - m_last_redir;
        m_squash  = Redirect_EX || (d < FC);
        m_stk_haz = m_stk && ((m_cyc - m_last_issue) <= SL);
        if (m_squash)                exp_outs = O_FLUSH;
        else if (m_lu || m_stk_haz)  exp_outs = O_STALL;
        else                         exp_outs = O_NONE;
        if (d >= 1 && d <= FC - 1)              exp_state = 2'd1;
        else if (m_prev_sh && !m_prev_flush)    exp_state = 2'd2;
        else                                    exp_state = 2'd0;
    endtask

    task automatic model_commit();
        if (Redirect_EX) m_last_redir = m_cyc;
        if (m_stk && !m_squash && !m_lu && !m_stk_haz) m_last_issue = m_cyc;
        m_prev_flush = m_squash;
        m_prev_sh    = m_stk_haz;
        if (exp_outs[0] && m_bubbles < 65535) m_bubbles++;
        m_cyc++;
    endtask

    task automatic do_reset();
        idle_in();
        reset = 1'b0;
        repeat (2) tick();
        reset = 1'b1;
        model_init();
    endtask

    // ------------------------------------------------------------------ tests
    task automatic test_reset();
        reset = 1'b0;
        idle_in();
        Redirect_EX = 1'b1;
        set_load_ex(4'd5); rs1_ID = 4'd5; Read_Enable_1_ID = 1'b1;
        tick();
        checks++;
        if (outs !== O_NONE) begin
            errors++; $display("FAIL reset_outs: got %b want %b", outs, O_NONE);
        end
        checks++;
        if (Hz_State !== 2'd0 || Bubble_Count !== 16'd0) begin
            errors++; $display("FAIL reset_regs: got state %0d count %0d want 0 0", Hz_State, Bubble_Count);
        end
    endtask

    task automatic test_load_use();
        do_reset();
        set_load_ex(4'd5); rs2_ID = 4'd5; Read_Enable_2_ID = 1'b1;
        settle();
        checks++;
        if (outs !== O_STALL) begin
            errors++; $display("FAIL lu_stall: got %b want %b", outs, O_STALL);
        end
        tick();
        idle_in();
        settle();
        checks++;
        if (outs !== O_NONE || Bubble_Count !== 16'd1) begin
            errors++; $display("FAIL lu_one_cycle: got %b cnt %0d want %b cnt 1", outs, Bubble_Count, O_NONE);
        end
        set_load_ex(4'd0); rs2_ID = 4'd0; Read_Enable_2_ID = 1'b1;
        settle();
        checks++;
        if (outs !== O_NONE) begin
            errors++; $display("FAIL lu_rd_zero: got %b want %b", outs, O_NONE);
        end
        tick();
        set_load_ex(4'd5); rs2_ID = 4'd5; Read_Enable_2_ID = 1'b0;
        settle();
        checks++;
        if (outs !== O_NONE) begin
            errors++; $display("FAIL lu_no_read: got %b want %b", outs, O_NONE);
        end
        tick();
        idle_in();
        settle();
        checks++;
        if (Bubble_Count !== 16'd1) begin
            errors++; $display("FAIL lu_count: got %0d want 1", Bubble_Count);
        end
    endtask

    task automatic test_redirect();
        do_reset();
        Redirect_EX = 1'b1;
        settle();
        checks++;
        if (outs !== O_FLUSH) begin
            errors++; $display("FAIL redir_t0: got %b want %b", outs, O_FLUSH);
        end
        tick();
        Redirect_EX = 1'b0;
        settle();
        checks++;
        if (outs !== O_FLUSH || Hz_State !== 2'd1) begin
            errors++; $display("FAIL redir_t1: got %b state %0d want %b state 1", outs, Hz_State, O_FLUSH);
        end
        tick();
        settle();
        checks++;
        if (outs !== O_NONE || Hz_State !== 2'd0 || Bubble_Count !== 16'd2) begin
            errors++; $display("FAIL redir_t2: got %b state %0d cnt %0d want %b 0 2", outs, Hz_State, Bubble_Count, O_NONE);
        end
        // Redirect again inside the squash window restarts it.
        Redirect_EX = 1'b1;
        tick();
        settle();
        checks++;
        if (outs !== O_FLUSH) begin
            errors++; $display("FAIL redir2_t1: got %b want %b", outs, O_FLUSH);
        end
        tick();
        Redirect_EX = 1'b0;
        settle();
        checks++;
        if (outs !== O_FLUSH || Hz_State !== 2'd1) begin
            errors++; $display("FAIL redir2_t2: got %b state %0d want %b state 1", outs, Hz_State, O_FLUSH);
        end
        tick();
        settle();
        checks++;
        if (outs !== O_NONE || Hz_State !== 2'd0 || Bubble_Count !== 16'd5) begin
            errors++; $display("FAIL redir2_t3: got %b state %0d cnt %0d want %b 0 5", outs, Hz_State, Bubble_Count, O_NONE);
        end
    endtask

    task automatic test_stack();
        do_reset();
        Stack_In_Enable_ID = 1'b1;
        settle();
        checks++;
        if (outs !== O_NONE) begin
            errors++; $display("FAIL stk_push_issue: got %b want %b", outs, O_NONE);
        end
        tick();
        Stack_In_Enable_ID = 1'b0; Stack_Out_Enable_ID = 1'b1;
        settle();
        checks++;
        if (outs !== O_STALL) begin
            errors++; $display("FAIL stk_t1: got %b want %b", outs, O_STALL);
        end
        tick();
        settle();
        checks++;
        if (outs !== O_STALL || Hz_State !== 2'd2) begin
            errors++; $display("FAIL stk_t2: got %b state %0d want %b state 2", outs, Hz_State, O_STALL);
        end
        tick();
        settle();
        checks++;
        if (outs !== O_NONE) begin
            errors++; $display("FAIL stk_t3_issue: got %b want %b", outs, O_NONE);
        end
        tick();
        idle_in();
        settle();
        checks++;
        if (Hz_State !== 2'd0 || Bubble_Count !== 16'd2) begin
            errors++; $display("FAIL stk_t4: got state %0d cnt %0d want 0 2", Hz_State, Bubble_Count);
        end
        repeat (3) tick();
    endtask

    task automatic test_priority();
        do_reset();
        Stack_In_Enable_ID = 1'b1;
        tick();
        // Redirect together with load-use and stack hazard
        Stack_In_Enable_ID = 1'b0; Stack_Out_Enable_ID = 1'b1; Redirect_EX = 1'b1;
        set_load_ex(4'd3); rs1_ID = 4'd3; Read_Enable_1_ID = 1'b1;
        settle();
        checks++;
        if (outs !== O_FLUSH) begin
            errors++; $display("FAIL prio_flush_wins: got %b want %b", outs, O_FLUSH);
        end
        tick();
        idle_in();
        settle();
        checks++;
        if (outs !== O_FLUSH) begin
            errors++; $display("FAIL prio_flush_cont: got %b want %b", outs, O_FLUSH);
        end
        tick();
        // Spacing elapsed during the flush and the squashed op did not reload.
        Stack_Out_Enable_ID = 1'b1;
        settle();
        checks++;
        if (outs !== O_NONE) begin
            errors++; $display("FAIL prio_stk_drained: got %b want %b", outs, O_NONE);
        end
        tick();
        settle();
        checks++;
        if (outs !== O_STALL) begin
            errors++; $display("FAIL prio_stk_reissue: got %b want %b", outs, O_STALL);
        end
        tick();
        idle_in();
        repeat (3) tick();
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            Redirect_EX         = ($urandom_range(0, 7) == 0);
            Mem_RD_EX           = 1'($urandom_range(0, 1));
            Write_Enable_EX     = ($urandom_range(0, 3) != 0);
            rd_EX               = REG_AW'($urandom_range(0, 3));
            rs1_ID              = REG_AW'($urandom_range(0, 3));
            rs2_ID              = REG_AW'($urandom_range(0, 3));
            Read_Enable_1_ID    = 1'($urandom_range(0, 1));
            Read_Enable_2_ID    = 1'($urandom_range(0, 1));
            Stack_In_Enable_ID  = ($urandom_range(0, 3) == 0);
            Stack_Out_Enable_ID = ($urandom_range(0, 3) == 0);
            settle();
            model_eval();
            checks++;
            if (outs !== exp_outs) begin
                errors++; $display("FAIL rnd_outs cyc %0d: got %b want %b", m_cyc, outs, exp_outs);
            end
            checks++;
            if (Hz_State !== exp_state) begin
                errors++; $display("FAIL rnd_state cyc %0d: got %0d want %0d", m_cyc, Hz_State, exp_state);
            end
            checks++;
            if (Bubble_Count !== 16'(m_bubbles)) begin
                errors++; $display("FAIL rnd_count cyc %0d: got %0d want %0d", m_cyc, Bubble_Count, m_bubbles);
            end
            model_commit();
            tick();
        end
        idle_in();
    endtask

    task automatic test_saturation();
        do_reset();
        Redirect_EX = 1'b1;
        repeat (65534) tick();
        checks++;
        if (Bubble_Count !== 16'hFFFE) begin
            errors++; $display("FAIL sat_pre: got %h want fffe", Bubble_Count);
        end
        repeat (70000 - 65534) tick();
        checks++;
        if (Bubble_Count !== 16'hFFFF) begin
            errors++; $display("FAIL sat_hold: got %h want ffff", Bubble_Count);
        end
        idle_in();
    endtask

    task automatic test_async_reset();
        do_reset();
        Redirect_EX = 1'b1;
        tick();
        Redirect_EX = 1'b0;
        settle();
        reset = 1'b0;
        #1;
        checks++;
        if (outs !== O_NONE || Hz_State !== 2'd0 || Bubble_Count !== 16'd0) begin
            errors++; $display("FAIL arst_flush: got %b state %0d cnt %0d want 0 0 0", outs, Hz_State, Bubble_Count);
        end
        tick();
        reset = 1'b1;
        tick();
        settle();
        checks++;
        if (outs !== O_NONE || Hz_State !== 2'd0 || Bubble_Count !== 16'd0) begin
            errors++; $display("FAIL arst_flush_after: got %b state %0d cnt %0d want 0 0 0", outs, Hz_State, Bubble_Count);
        end
        // Mid stack wait
        Stack_In_Enable_ID = 1'b1;
        tick();
        Stack_In_Enable_ID = 1'b0; Stack_Out_Enable_ID = 1'b1;
        tick();
        settle();
        checks++;
        if (outs !== O_STALL || Hz_State !== 2'd2) begin
            errors++; $display("FAIL arst_stk_pre: got %b state %0d want %b state 2", outs, Hz_State, O_STALL);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (outs !== O_NONE || Hz_State !== 2'd0 || Bubble_Count !== 16'd0) begin
            errors++; $display("FAIL arst_stk: got %b state %0d cnt %0d want 0 0 0", outs, Hz_State, Bubble_Count);
        end
        tick();
        reset = 1'b1;
        idle_in();
        tick();
        Stack_Out_Enable_ID = 1'b1;
        settle();
        checks++;
        if (outs !== O_NONE || Bubble_Count !== 16'd0) begin
            errors++; $display("FAIL arst_stk_after: got %b cnt %0d want %b 0", outs, Bubble_Count, O_NONE);
        end
        tick();
        idle_in();
    endtask

    // ------------------------------------------------------------- sequencer
    initial begin
        idle_in();
        test_reset();
        test_load_use();
        test_redirect();
        test_stack();
        test_priority();
        test_random();
        test_async_reset();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
